ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 214 +++++++++++++++++++++
 tb/tb_ram_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Byte-stream loader: parses cmd/addr/len frames and writes packed words into IRAM/DRAM.
// Define RAM_LOADER_READBACK_EN to compile in the read commands and the tx readback path.
module ram_loader #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_valid_i,
    output logic            rx_ready_o,
    output logic [7:0]      tx_data_o,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output logic            iram_wr_sel_o,
    output logic            iram_rd_sel_o,
    output logic            dram_wr_sel_o,
    output logic            dram_rd_sel_o,
    output logic            iram_wr_en_o,
    output logic            dram_wr_en_o,
    output logic [XLEN-1:0] wr_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [3:0]      wr_byte_en_o,
    output logic [XLEN-1:0] rd_addr_o,
    input  logic [7:0]      iram_rd_byte_i,
    input  logic [7:0]      dram_rd_byte_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_WDATA   = 3'd3;
    localparam logic [2:0] S_WSTROBE = 3'd4;
    localparam logic [2:0] S_RREQ    = 3'd5;
    localparam logic [2:0] S_RWAIT   = 3'd6;
    localparam logic [2:0] S_RSEND   = 3'd7;

    logic [2:0]      state_reg;
    logic            is_read_reg;
    logic            is_dram_reg;
    logic            err_reg;
    logic [1:0]      byte_idx_reg;
    logic [7:0]      len_hi_reg;
    logic [XLEN-1:0] addr_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [31:0]     data_reg;
    logic [3:0]      be_reg;
    logic [XLEN-1:0] wr_addr_reg;
`ifdef RAM_LOADER_READBACK_EN
    logic [7:0]      tx_data_reg;
`endif

    logic        cmd_ok;
    logic        cmd_read;
    logic        cmd_dram;
    logic        rx_fire;
    logic [1:0]  lane;
    logic        last_byte;
    logic [15:0] len_full;

    always_comb begin
        cmd_ok   = 1'b0;
        cmd_read = 1'b0;
        cmd_dram = 1'b0;
        case (rx_data_i)
            8'h01: cmd_ok = 1'b1;
            8'h02: begin cmd_ok = 1'b1; cmd_dram = 1'b1; end
`ifdef RAM_LOADER_READBACK_EN
            8'h11: begin cmd_ok = 1'b1; cmd_read = 1'b1; end
            8'h12: begin cmd_ok = 1'b1; cmd_read = 1'b1; cmd_dram = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign rx_ready_o = ~rst_i & ((state_reg == S_IDLE) | (state_reg == S_ADDR) |
                                  (state_reg == S_LEN)  | (state_reg == S_WDATA));
    assign rx_fire    = rx_valid_i & rx_ready_o;
    assign lane       = addr_reg[1:0];
    assign last_byte  = (cnt_reg == LEN_W'(1));
    assign len_full   = {len_hi_reg, rx_data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            is_read_reg  <= 1'b0;
            is_dram_reg  <= 1'b0;
            err_reg      <= 1'b0;
            byte_idx_reg <= 2'd0;
            len_hi_reg   <= 8'd0;
            addr_reg     <= '0;
            cnt_reg      <= '0;
            data_reg     <= '0;
            be_reg       <= '0;
            wr_addr_reg  <= '0;
`ifdef RAM_LOADER_READBACK_EN
            tx_data_reg  <= 8'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (rx_fire) begin
                        if (cmd_ok) begin
                            state_reg    <= S_ADDR;
                            is_read_reg  <= cmd_read;
                            is_dram_reg  <= cmd_dram;
                            byte_idx_reg <= 2'd0;
                            addr_reg     <= '0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_reg     <= {addr_reg[XLEN-9:0], rx_data_i};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (rx_fire) begin
                        if (byte_idx_reg == 2'd0) begin
                            len_hi_reg   <= rx_data_i;
                            byte_idx_reg <= 2'd1;
                        end else begin
                            byte_idx_reg <= 2'd0;
                            cnt_reg      <= LEN_W'(len_full);
                            data_reg     <= '0;
                            be_reg       <= '0;
                            if (len_full == 16'd0) begin
                                state_reg <= S_IDLE;
                            end else begin
                                state_reg <= is_read_reg ? S_RREQ : S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_fire) begin
                        data_reg[{lane, 3'b000} +: 8] <= rx_data_i;
                        be_reg[lane] <= 1'b1;
                        wr_addr_reg  <= {addr_reg[XLEN-1:2], 2'b00};
                        addr_reg     <= addr_reg + XLEN'(1);
                        cnt_reg      <= cnt_reg - LEN_W'(1);
                        // Flush when the word is full or the frame ends mid-word.
                        if (lane == 2'd3 || last_byte) begin
                            state_reg <= S_WSTROBE;
                        end
                    end
                end
                S_WSTROBE: begin
                    data_reg  <= '0;
                    be_reg    <= '0;
                    state_reg <= (cnt_reg == '0) ? S_IDLE : S_WDATA;
                end
`ifdef RAM_LOADER_READBACK_EN
                S_RREQ: begin
                    state_reg <= S_RWAIT;
                end
                S_RWAIT: begin
                    // RAM read data lags the address by one cycle; latch it so a tx stall holds it.
                    tx_data_reg <= is_dram_reg ? dram_rd_byte_i : iram_rd_byte_i;
                    state_reg   <= S_RSEND;
                end
                S_RSEND: begin
                    if (tx_ready_i) begin
                        addr_reg  <= addr_reg + XLEN'(1);
                        cnt_reg   <= cnt_reg - LEN_W'(1);
                        state_reg <= last_byte ? S_IDLE : S_RREQ;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    logic strobe;
    assign strobe = (state_reg == S_WSTROBE);

    assign busy_o        = (state_reg != S_IDLE);
    assign err_o         = err_reg;
    assign iram_wr_sel_o = busy_o & ~is_read_reg & ~is_dram_reg;
    assign dram_wr_sel_o = busy_o & ~is_read_reg &  is_dram_reg;
    assign iram_wr_en_o  = strobe & ~is_dram_reg;
    assign dram_wr_en_o  = strobe &  is_dram_reg;
    assign wr_addr_o     = strobe ? wr_addr_reg : '0;
    assign wr_data_o     = strobe ? XLEN'(data_reg) : '0;
    assign wr_byte_en_o  = strobe ? be_reg : 4'd0;

`ifdef RAM_LOADER_READBACK_EN
    logic read_phase;
    assign read_phase    = (state_reg == S_RREQ) | (state_reg == S_RWAIT) | (state_reg == S_RSEND);
    assign iram_rd_sel_o = busy_o & is_read_reg & ~is_dram_reg;
    assign dram_rd_sel_o = busy_o & is_read_reg &  is_dram_reg;
    assign rd_addr_o     = read_phase ? addr_reg : '0;
    assign tx_valid_o    = (state_reg == S_RSEND);
    assign tx_data_o     = (state_reg == S_RSEND) ? tx_data_reg : 8'd0;
`else
    logic unused_rd;
    assign unused_rd     = ^{tx_ready_i, iram_rd_byte_i, dram_rd_byte_i};
    assign iram_rd_sel_o = 1'b0;
    assign dram_rd_sel_o = 1'b0;
    assign rd_addr_o     = '0;
    assign tx_valid_o    = 1'b0;
    assign tx_data_o     = 8'd0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus pushes expected RAM writes / readback bytes,
// monitors pop and compare whenever the DUT strobes a write or hands off a tx byte.
`timescale 1ns/1ps
module tb_ram_loader;
    localparam int XLEN  = 32;
    localparam int LEN_W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'd0;
    logic            rx_valid = 1'b0;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic            iram_wr_sel, iram_rd_sel, dram_wr_sel, dram_rd_sel;
    logic            iram_wr_en, dram_wr_en;
    logic [XLEN-1:0] wr_addr, wr_data, rd_addr;
    logic [3:0]      wr_byte_en;
    logic [7:0]      iram_rd_byte = 8'd0;
    logic [7:0]      dram_rd_byte = 8'd0;
    logic            busy, err;

    ram_loader #(.XLEN(XLEN), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .iram_wr_sel_o(iram_wr_sel), .iram_rd_sel_o(iram_rd_sel),
        .dram_wr_sel_o(dram_wr_sel), .dram_rd_sel_o(dram_rd_sel),
        .iram_wr_en_o(iram_wr_en), .dram_wr_en_o(dram_wr_en),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_byte_en_o(wr_byte_en),
        .rd_addr_o(rd_addr),
        .iram_rd_byte_i(iram_rd_byte), .dram_rd_byte_i(dram_rd_byte),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models
    logic [7:0] iram_mem [0:255];
    logic [7:0] dram_mem [0:255];
    always @(posedge clk) begin
        iram_rd_byte <= iram_mem[rd_addr[7:0]];
        dram_rd_byte <= dram_mem[rd_addr[7:0]];
    end

    typedef struct {
        logic        dram;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;
    typedef struct {
        logic [7:0]  data;
        logic [31:0] addr;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && (iram_wr_en || dram_wr_en)) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=0x%08h en=%b required none", wr_addr, wr_byte_en);
            end else begin
                e = wr_q.pop_front();
                check("wr_en",   {30'd0, dram_wr_en, iram_wr_en}, e.dram ? 32'd2 : 32'd1);
                check("wr_sel",  {28'd0, iram_wr_sel, dram_wr_sel, iram_rd_sel, dram_rd_sel},
                      e.dram ? 32'h4 : 32'h8);
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("wr_be",   {28'd0, wr_byte_en}, {28'd0, e.be});
                $display("WR %s addr=0x%08h data=0x%08h be=%b", dram_wr_en ? "DRAM" : "IRAM",
                         wr_addr, wr_data, wr_byte_en);
            end
        end
    end

    always @(negedge clk) begin
        rd_t r;
        if (!rst && tx_valid && tx_ready) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual=0x%02h required none", tx_data);
            end else begin
                r = rd_q.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, r.data});
                check("rd_addr", rd_addr, r.addr);
                $display("RD addr=0x%08h data=0x%02h", rd_addr, tx_data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_accept_timeout actual=rx_ready 0 required=1 byte=0x%02h", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [15:0] len, input logic [31:0] payload, input int npay);
        logic [31:0] p;
        p = payload;
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[31 - 8*i -: 8]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int i = 0; i < npay; i++) send_byte(p[31 - 8*i -: 8]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic any_out();
        return |{tx_valid, tx_data, iram_wr_sel, iram_rd_sel, dram_wr_sel, dram_rd_sel,
                 iram_wr_en, dram_wr_en, wr_addr, wr_data, wr_byte_en, rd_addr, busy, err};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            iram_mem[i] = 8'h00;
            dram_mem[i] = 8'h00;
        end
        dram_mem[8'h20] = 8'h5A;
        dram_mem[8'h21] = 8'hA5;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {31'd0, any_out()}, 32'd0);
        check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Aligned full-word IRAM write
        wr_q.push_back('{dram: 1'b0, addr: 32'h10, data: 32'h44332211, be: 4'b1111});
        send_byte(8'h01);
        check("sel_after_cmd", {29'd0, busy, iram_wr_sel, dram_wr_sel}, 32'b110);
        for (int i = 0; i < 4; i++) send_byte(i == 3 ? 8'h10 : 8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle();

        // Unaligned DRAM write with partial first and last words
        wr_q.push_back('{dram: 1'b1, addr: 32'h4, data: 32'hBBAA0000, be: 4'b1100});
        wr_q.push_back('{dram: 1'b1, addr: 32'h8, data: 32'h000000CC, be: 4'b0001});
        send_frame(8'h02, 32'h6, 16'd3, 32'hAABBCC00, 3);
        wait_idle();

`ifdef RAM_LOADER_READBACK_EN
        // DRAM readback with a 3-cycle tx stall; rx byte offered during the stall must be refused
        rd_q.push_back('{data: 8'h5A, addr: 32'h20});
        rd_q.push_back('{data: 8'hA5, addr: 32'h21});
        send_frame(8'h12, 32'h20, 16'd2, 32'd0, 0);
        begin
            int n;
            n = 0;
            while (!tx_valid && n < 50) begin @(posedge clk); #1; n++; end
        end
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_tx_data", {24'd0, tx_data}, 32'h5A);
            check("stall_rd_addr", rd_addr, 32'h20);
            check("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
            check("stall_rd_sel", {30'd0, dram_rd_sel, iram_rd_sel}, 32'b10);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_idle();
        tx_ready = 1'b0;
        check("read_no_err", {31'd0, err}, 32'd0);
        check("read_q_empty", rd_q.size(), 32'd0);
`else
        // Read commands are illegal without the readback path
        send_byte(8'h12);
        check("read_cmd_err", {31'd0, err}, 32'd1);
        check("read_cmd_idle", {27'd0, busy, iram_wr_sel, dram_wr_sel, iram_rd_sel, dram_rd_sel}, 32'd0);
`endif

        // Bad command, then a valid frame still executes
        send_byte(8'h7F);
        check("bad_cmd_err", {31'd0, err}, 32'd1);
        check("bad_cmd_idle", {27'd0, busy, iram_wr_sel, dram_wr_sel, iram_rd_sel, dram_rd_sel}, 32'd0);
        wr_q.push_back('{dram: 1'b0, addr: 32'h0, data: 32'h00000077, be: 4'b0001});
        send_frame(8'h01, 32'h0, 16'd1, 32'h77000000, 1);
        wait_idle();
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-payload discards the partial word
        send_frame(8'h01, 32'h40, 16'd4, 32'h99880000, 2);
        rst = 1'b1;
        #2;
        check("midreset_outputs", {31'd0, any_out()}, 32'd0);
        check("midreset_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_busy_err", {30'd0, busy, err}, 32'd0);
        wr_q.push_back('{dram: 1'b1, addr: 32'h100, data: 32'h00000201, be: 4'b0011});
        send_frame(8'h02, 32'h100, 16'd2, 32'h01020000, 2);
        wait_idle();

        // Address wrap across the top of the address space
        wr_q.push_back('{dram: 1'b0, addr: 32'hFFFFFFFC, data: 32'hADDE0000, be: 4'b1100});
        wr_q.push_back('{dram: 1'b0, addr: 32'h00000000, data: 32'h0000EFBE, be: 4'b0011});
        send_frame(8'h01, 32'hFFFFFFFE, 16'd4, 32'hDEADBEEF, 4);
        wait_idle();

        // Zero-length frame returns to idle with no write
        send_frame(8'h01, 32'h50, 16'd0, 32'd0, 0);
        @(posedge clk); #1;
        check("zero_len_idle", {31'd0, busy}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("wr_q_empty", wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
